// File: rtl/definitions_pkg.sv
// Shared image geometry, pixel types and Gaussian kernel constants for the Canny pipeline.
// The kernel table documents the weights; the datapath realises them with fixed shifts.
package definitions_pkg;

    localparam int IMAGE_WIDTH  = 512;
    localparam int IMAGE_HEIGHT = 512;
    localparam int PIX_W        = 8;

    localparam int GAUSS3_SHIFT = 4;
    localparam int GAUSS3_ROUND = 8;

    // Row-major 3x3 weights, sum 16: corners 1, edges 2, centre 4
    localparam int gaussian_kernel_3 [0:8] = '{1, 2, 1,
                                              2, 4, 2,
                                              1, 2, 1};

    typedef logic [PIX_W-1:0] pixel_t;
    typedef pixel_t window3_t [0:8];

endpackage

// File: rtl/line_buffer.sv
// One image line of storage addressed by column; combinational read, write on enable.
// The read returns the old word when the same address is written in the same cycle.
module line_buffer #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     i_en,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]         i_wr_dat,
    output logic [WIDTH-1:0]         o_rd_dat
);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[i_addr] <= i_wr_dat;
        end
    end

    assign o_rd_dat = r_mem[i_addr];

endmodule

// File: rtl/gaussian_blur_3x3.sv
// Streaming 3x3 Gaussian blur emitting interior pixels; output 2 enabled cycles after the accept.
// Whole pipeline advances only when the output register is empty or being drained (in_ready = en).
module gaussian_blur_3x3 #(
    parameter int IMAGE_WIDTH  = definitions_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = definitions_pkg::IMAGE_HEIGHT,
    parameter int PIX_W        = definitions_pkg::PIX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_sof,
    output logic             out_eol
);

    import definitions_pkg::*;

    localparam int CW    = $clog2(IMAGE_WIDTH);
    localparam int RW    = $clog2(IMAGE_HEIGHT);
    localparam int SUM_W = PIX_W + 4;

    localparam logic [CW-1:0] LAST_COL = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMAGE_HEIGHT - 1);

    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [PIX_W-1:0] r_win [0:8];
    logic             r_v1, r_sof1, r_eol1;
    logic [SUM_W-1:0] r_sum;
    logic             r_v2, r_sof2, r_eol2;
    logic             r_out_valid, r_out_sof, r_out_eol;
    logic [PIX_W-1:0] r_out_pixel;

    logic             w_en;
    logic             w_acc;
    logic [CW-1:0]    w_col;
    logic [RW-1:0]    w_row;
    logic             w_elig;
    logic [PIX_W-1:0] w_lb0_rd;
    logic [PIX_W-1:0] w_lb1_rd;
    logic [SUM_W-1:0] w_sum;

    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;
    assign w_acc    = in_valid && w_en;

    // in_sof re-anchors the raster position on the pixel that carries it
    assign w_col  = in_sof ? '0 : r_col;
    assign w_row  = in_sof ? '0 : r_row;
    assign w_elig = (w_row >= RW'(2)) && (w_col >= CW'(2));

    line_buffer #(
        .DEPTH (IMAGE_WIDTH),
        .WIDTH (PIX_W)
    ) u_lb0 (
        .clk      (clk),
        .i_en     (w_acc),
        .i_addr   (w_col),
        .i_wr_dat (in_pixel),
        .o_rd_dat (w_lb0_rd)
    );

    line_buffer #(
        .DEPTH (IMAGE_WIDTH),
        .WIDTH (PIX_W)
    ) u_lb1 (
        .clk      (clk),
        .i_en     (w_acc),
        .i_addr   (w_col),
        .i_wr_dat (w_lb0_rd),
        .o_rd_dat (w_lb1_rd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            if (w_col == LAST_COL) begin
                r_col <= '0;
                r_row <= (w_row == LAST_ROW) ? '0 : w_row + RW'(1);
            end else begin
                r_col <= w_col + CW'(1);
                r_row <= w_row;
            end
        end
    end

    // Window rows: [0..2] = r-2, [3..5] = r-1, [6..8] = r; rightmost column is newest
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_acc) begin
            for (int r = 0; r < 3; r++) begin
                r_win[3*r]   <= r_win[3*r+1];
                r_win[3*r+1] <= r_win[3*r+2];
            end
            r_win[2] <= w_lb1_rd;
            r_win[5] <= w_lb0_rd;
            r_win[8] <= in_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_sof1 <= 1'b0;
            r_eol1 <= 1'b0;
        end else if (w_en) begin
            r_v1   <= w_acc && w_elig;
            r_sof1 <= w_acc && w_elig && (w_row == RW'(2)) && (w_col == CW'(2));
            r_eol1 <= w_acc && w_elig && (w_col == LAST_COL);
        end
    end

    always_comb begin
        w_sum = SUM_W'(r_win[0]) + SUM_W'(r_win[2])
              + SUM_W'(r_win[6]) + SUM_W'(r_win[8])
              + (SUM_W'(r_win[1]) << 1) + (SUM_W'(r_win[3]) << 1)
              + (SUM_W'(r_win[5]) << 1) + (SUM_W'(r_win[7]) << 1)
              + (SUM_W'(r_win[4]) << 2);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_v2   <= 1'b0;
            r_sof2 <= 1'b0;
            r_eol2 <= 1'b0;
        end else if (w_en) begin
            r_sum  <= w_sum;
            r_v2   <= r_v1;
            r_sof2 <= r_sof1;
            r_eol2 <= r_eol1;
        end
    end

    // Sum of 16 weights tops out at 16*max+8, so the rounded quotient always fits PIX_W
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_pixel <= '0;
            r_out_sof   <= 1'b0;
            r_out_eol   <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= r_v2;
            r_out_pixel <= PIX_W'((r_sum + SUM_W'(GAUSS3_ROUND)) >> GAUSS3_SHIFT);
            r_out_sof   <= r_sof2;
            r_out_eol   <= r_eol2;
        end
    end

    assign out_valid = r_out_valid;
    assign out_pixel = r_out_pixel;
    assign out_sof   = r_out_sof;
    assign out_eol   = r_out_eol;

endmodule

// File: tb/tb_gaussian_blur_3x3.sv
// Directed bench for gaussian_blur_3x3 on an 8x6 frame: reset, constant, impulse, ramp,
// back-to-back frames, random backpressure, mid-frame reset and mid-frame in_sof.
module tb_gaussian_blur_3x3;

    localparam int W = 8;
    localparam int H = 6;
    localparam int NOUT = (W - 2) * (H - 2);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_pixel;
    logic       in_sof;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_pixel;
    logic       out_sof;
    logic       out_eol;

    int n_vec = 0;
    int n_err = 0;

    bit         rand_rdy  = 1'b0;
    bit         stall_chk = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_pix;
    logic       prev_sof, prev_eol;

    logic [7:0] img [0:H-1][0:W-1];
    logic [7:0] q_pix[$];
    logic       q_sof[$];
    logic       q_eol[$];
    logic [7:0] e_pix[$];
    logic       e_sof[$];
    logic       e_eol[$];

    always #5 clk = ~clk;

    gaussian_blur_3x3 #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .PIX_W        (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel),
        .out_sof   (out_sof),
        .out_eol   (out_eol)
    );

    // Output collector and stall-stability monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            q_pix.push_back(out_pixel);
            q_sof.push_back(out_sof);
            q_eol.push_back(out_eol);
        end
        if (stall_chk && rst_n) begin
            if (prev_stall) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_pixel !== prev_pix ||
                    out_sof !== prev_sof || out_eol !== prev_eol) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%b pix=%0d sof=%b eol=%b, want v=1 pix=%0d sof=%b eol=%b",
                             out_valid, out_pixel, out_sof, out_eol, prev_pix, prev_sof, prev_eol);
                end
            end
            if (out_valid && !out_ready) begin
                n_vec++;
                if (in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_in_ready: got %b, want 0", in_ready);
                end
            end
        end
        prev_stall = rst_n && out_valid && !out_ready;
        prev_pix   = out_pixel;
        prev_sof   = out_sof;
        prev_eol   = out_eol;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(output bit acc);
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic send_range(input int lo, input int hi, input bit sof_en);
        bit a;
        int guard;
        for (int i = lo; i < hi; i++) begin
            in_valid = 1'b1;
            in_pixel = img[i / W][i % W];
            in_sof   = sof_en && (i == 0);
            guard = 0;
            do begin
                tick(a);
                guard++;
            end while (!a && guard < 1000);
            if (!a) begin
                n_vec++;
                n_err++;
                $display("FAIL accept_timeout: pixel %0d not accepted, in_ready=%b", i, in_ready);
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic wait_outputs(input int n);
        bit a;
        int g = 0;
        while (q_pix.size() < n && g < 1000) begin
            tick(a);
            g++;
        end
        repeat (6) tick(a);
    endtask

    task automatic clear_q();
        q_pix.delete(); q_sof.delete(); q_eol.delete();
        e_pix.delete(); e_sof.delete(); e_eol.delete();
    endtask

    // Reference convolution with the 1-2-1 outer-product weights and round-to-nearest
    task automatic push_model(input bit sof_on);
        int s;
        for (int r = 1; r < H - 1; r++) begin
            for (int c = 1; c < W - 1; c++) begin
                s = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        s += int'(img[r+dr][c+dc]) * ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1);
                e_pix.push_back(8'((s + 8) / 16));
                e_sof.push_back(sof_on && r == 1 && c == 1);
                e_eol.push_back(c == W - 2);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || out_pixel !== 8'd0 || out_sof !== 1'b0 ||
            out_eol !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: got v=%b pix=%0d sof=%b eol=%b rdy=%b, want 0 0 0 0 1",
                     out_valid, out_pixel, out_sof, out_eol, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_constant();
        clear_q();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'd100;
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++) begin
                e_pix.push_back(8'd100);
                e_sof.push_back(r == 1 && c == 1);
                e_eol.push_back(c == W - 2);
            end
        send_range(0, W * H, 1'b1);
        wait_outputs(NOUT);
        n_vec++;
        if (q_pix.size() !== e_pix.size()) begin
            n_err++;
            $display("FAIL const_count: got %0d outputs, want %0d", q_pix.size(), e_pix.size());
        end
        for (int i = 0; i < e_pix.size() && i < q_pix.size(); i++) begin
            n_vec++;
            if (q_pix[i] !== e_pix[i] || q_sof[i] !== e_sof[i] || q_eol[i] !== e_eol[i]) begin
                n_err++;
                $display("FAIL const_out[%0d]: got pix=%0d sof=%b eol=%b, want pix=%0d sof=%b eol=%b",
                         i, q_pix[i], q_sof[i], q_eol[i], e_pix[i], e_sof[i], e_eol[i]);
            end
        end
    endtask

    task automatic test_impulse();
        int dr, dc;
        clear_q();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'd0;
        img[3][3] = 8'd255;
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++) begin
                dr = (r > 3) ? r - 3 : 3 - r;
                dc = (c > 3) ? c - 3 : 3 - c;
                e_pix.push_back((dr == 0 && dc == 0) ? 8'd64 :
                                (dr + dc == 1)       ? 8'd32 :
                                (dr == 1 && dc == 1) ? 8'd16 : 8'd0);
                e_sof.push_back(r == 1 && c == 1);
                e_eol.push_back(c == W - 2);
            end
        send_range(0, W * H, 1'b1);
        wait_outputs(NOUT);
        n_vec++;
        if (q_pix.size() !== e_pix.size()) begin
            n_err++;
            $display("FAIL impulse_count: got %0d outputs, want %0d", q_pix.size(), e_pix.size());
        end
        for (int i = 0; i < e_pix.size() && i < q_pix.size(); i++) begin
            n_vec++;
            if (q_pix[i] !== e_pix[i] || q_sof[i] !== e_sof[i] || q_eol[i] !== e_eol[i]) begin
                n_err++;
                $display("FAIL impulse_out[%0d]: got pix=%0d sof=%b eol=%b, want pix=%0d sof=%b eol=%b",
                         i, q_pix[i], q_sof[i], q_eol[i], e_pix[i], e_sof[i], e_eol[i]);
            end
        end
    endtask

    // Ramp plus first-output latency: (2,2) accepted, bubbles follow, output appears after 2 more edges
    task automatic test_ramp();
        logic v_a, v_b, v_c;
        logic [7:0] p_c;
        clear_q();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'(c * 10);
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++) begin
                e_pix.push_back(8'(c * 10));
                e_sof.push_back(r == 1 && c == 1);
                e_eol.push_back(c == W - 2);
            end
        send_range(0, 2 * W + 3, 1'b1);
        @(negedge clk); v_a = out_valid;
        @(posedge clk); #1;
        @(negedge clk); v_b = out_valid;
        @(posedge clk); #1;
        @(negedge clk); v_c = out_valid; p_c = out_pixel;
        @(posedge clk); #1;
        n_vec++;
        if (v_a !== 1'b0 || v_b !== 1'b0) begin
            n_err++;
            $display("FAIL ramp_latency_early: got valid %b,%b after 0/1 edges, want 0,0", v_a, v_b);
        end
        n_vec++;
        if (v_c !== 1'b1 || p_c !== 8'd10) begin
            n_err++;
            $display("FAIL ramp_latency_first: got v=%b pix=%0d, want v=1 pix=10", v_c, p_c);
        end
        for (int i = 2 * W + 3; i < W * H; i++) begin
            in_valid = 1'b1;
            in_pixel = img[i / W][i % W];
            send_range(i, i + 1, 1'b0);
        end
        wait_outputs(NOUT);
        n_vec++;
        if (q_pix.size() !== e_pix.size()) begin
            n_err++;
            $display("FAIL ramp_count: got %0d outputs, want %0d", q_pix.size(), e_pix.size());
        end
        for (int i = 0; i < e_pix.size() && i < q_pix.size(); i++) begin
            n_vec++;
            if (q_pix[i] !== e_pix[i] || q_sof[i] !== e_sof[i] || q_eol[i] !== e_eol[i]) begin
                n_err++;
                $display("FAIL ramp_out[%0d]: got pix=%0d sof=%b eol=%b, want pix=%0d sof=%b eol=%b",
                         i, q_pix[i], q_sof[i], q_eol[i], e_pix[i], e_sof[i], e_eol[i]);
            end
        end
    endtask

    // Second frame without in_sof relies on row wrap; its first output still carries out_sof
    task automatic test_back_to_back();
        clear_q();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'($urandom_range(0, 255));
        push_model(1'b1);
        push_model(1'b1);
        send_range(0, W * H, 1'b1);
        send_range(0, W * H, 1'b0);
        wait_outputs(2 * NOUT);
        n_vec++;
        if (q_pix.size() !== e_pix.size()) begin
            n_err++;
            $display("FAIL b2b_count: got %0d outputs, want %0d", q_pix.size(), e_pix.size());
        end
        for (int i = 0; i < e_pix.size() && i < q_pix.size(); i++) begin
            n_vec++;
            if (q_pix[i] !== e_pix[i] || q_sof[i] !== e_sof[i] || q_eol[i] !== e_eol[i]) begin
                n_err++;
                $display("FAIL b2b_out[%0d]: got pix=%0d sof=%b eol=%b, want pix=%0d sof=%b eol=%b",
                         i, q_pix[i], q_sof[i], q_eol[i], e_pix[i], e_sof[i], e_eol[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_q();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'($urandom_range(0, 255));
        push_model(1'b1);
        rand_rdy  = 1'b1;
        stall_chk = 1'b1;
        send_range(0, W * H, 1'b1);
        wait_outputs(NOUT);
        rand_rdy = 1'b0;
        wait_outputs(NOUT);
        stall_chk = 1'b0;
        n_vec++;
        if (q_pix.size() !== e_pix.size()) begin
            n_err++;
            $display("FAIL bp_count: got %0d outputs, want %0d", q_pix.size(), e_pix.size());
        end
        for (int i = 0; i < e_pix.size() && i < q_pix.size(); i++) begin
            n_vec++;
            if (q_pix[i] !== e_pix[i] || q_sof[i] !== e_sof[i] || q_eol[i] !== e_eol[i]) begin
                n_err++;
                $display("FAIL bp_out[%0d]: got pix=%0d sof=%b eol=%b, want pix=%0d sof=%b eol=%b",
                         i, q_pix[i], q_sof[i], q_eol[i], e_pix[i], e_sof[i], e_eol[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        clear_q();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'd180;
        send_range(0, 3 * W + 4, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || out_pixel !== 8'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_state: got v=%b pix=%0d rdy=%b, want v=0 pix=0 rdy=1",
                     out_valid, out_pixel, in_ready);
        end
        clear_q();
        @(posedge clk);
        #1;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'($urandom_range(0, 255));
        push_model(1'b1);
        send_range(0, W * H, 1'b1);
        wait_outputs(NOUT);
        n_vec++;
        if (q_pix.size() !== e_pix.size()) begin
            n_err++;
            $display("FAIL midreset_count: got %0d outputs, want %0d", q_pix.size(), e_pix.size());
        end
        for (int i = 0; i < e_pix.size() && i < q_pix.size(); i++) begin
            n_vec++;
            if (q_pix[i] !== e_pix[i] || q_sof[i] !== e_sof[i] || q_eol[i] !== e_eol[i]) begin
                n_err++;
                $display("FAIL midreset_out[%0d]: got pix=%0d sof=%b eol=%b, want pix=%0d sof=%b eol=%b",
                         i, q_pix[i], q_sof[i], q_eol[i], e_pix[i], e_sof[i], e_eol[i]);
            end
        end
    endtask

    // Frame A stops before (4,5); its 15 eligible windows drain, then frame B restarts with in_sof
    task automatic test_sof_midframe();
        clear_q();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'd200;
        for (int i = 0; i < 15; i++) begin
            e_pix.push_back(8'd200);
            e_sof.push_back(i == 0);
            e_eol.push_back(i == 5 || i == 11);
        end
        send_range(0, 4 * W + 5, 1'b1);
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'($urandom_range(0, 255));
        push_model(1'b1);
        send_range(0, W * H, 1'b1);
        wait_outputs(15 + NOUT);
        n_vec++;
        if (q_pix.size() !== e_pix.size()) begin
            n_err++;
            $display("FAIL midsof_count: got %0d outputs, want %0d", q_pix.size(), e_pix.size());
        end
        for (int i = 0; i < e_pix.size() && i < q_pix.size(); i++) begin
            n_vec++;
            if (q_pix[i] !== e_pix[i] || q_sof[i] !== e_sof[i] || q_eol[i] !== e_eol[i]) begin
                n_err++;
                $display("FAIL midsof_out[%0d]: got pix=%0d sof=%b eol=%b, want pix=%0d sof=%b eol=%b",
                         i, q_pix[i], q_sof[i], q_eol[i], e_pix[i], e_sof[i], e_eol[i]);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pixel  = 8'd0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_constant();
        test_impulse();
        test_ramp();
        test_back_to_back();
        test_backpressure();
        test_reset_midframe();
        test_sof_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
